// File: rtl/main_control_fsm.sv
// Multicycle datapath main controller: Moore FSM sequencing fetch, decode, memory, ALU, branch and jump.
// Optional addi support is enabled by defining MAIN_CTRL_ADDI_EN.
//
// state  | meaning
// IDLE   | post-reset idle, all strobes low, enters FETCH next cycle
// FETCH  | instruction read; IR and PC update when mem_ready
// DECODE | register read, branch target precompute, opcode dispatch
// MEMADR | load/store effective address
// MEMRD  | data read, held until mem_ready
// MEMWB  | load writeback to rt
// MEMWR  | data write, held until mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type writeback to rd
// BRANCH | beq compare and conditional PC update
// JUMP   | unconditional PC update to jump target
// ADDIEX | addi ALU operation (MAIN_CTRL_ADDI_EN only)
// ADDIWB | addi writeback to rt (MAIN_CTRL_ADDI_EN only)
module main_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  assign state = r_state;

  always_comb begin
    w_next_state  = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;

    case (r_state)
      S_IDLE: w_next_state = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_next_state = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
`ifdef MAIN_CTRL_ADDI_EN
          OP_ADDI:      w_next_state = S_ADDIEX;
`endif
          default: begin
            illegal_op   = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end

      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next_state = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end

`ifdef MAIN_CTRL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next_state = S_ADDIWB;
      end

      S_ADDIWB: reg_write = 1'b1;
`endif

      // Unused encodings (13-15, and 11/12 without addi) recover to FETCH with strobes low.
      default: w_next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed self-checking bench for main_control_fsm; expected state/strobe vectors are hand-derived.
// Follows MAIN_CTRL_ADDI_EN for the addi expectations.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[1:0], illegal_op}
  logic [16:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};

  localparam logic [16:0] O_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_FETCH_R = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] O_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] O_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] O_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] O_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [16:0] O_ALUWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] O_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] O_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
  localparam logic [16:0] O_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_outs);
    @(posedge clk);
    #1;
    chk({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
    chk({tag, "_outs"}, {15'd0, outs}, {15'd0, exp_outs});
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_outs", {15'd0, outs}, {15'd0, O_ZERO});
    rst_n = 1'b1;
    #1;
    chk("idle_hold", {28'd0, state}, 32'd0);

    // R-type
    step("r_fetch",  4'd1, O_FETCH_R);
    step("r_decode", 4'd2, O_DECODE);
    step("r_exec",   4'd7, O_EXEC);
    step("r_aluwb",  4'd8, O_ALUWB);
    step("r_done",   4'd1, O_FETCH_R);

    // lw with two wait cycles in MEMRD
    opcode = 6'b100011;
    step("lw_decode", 4'd2, O_DECODE);
    step("lw_memadr", 4'd3, O_MEMADR);
    mem_ready = 1'b0;
    step("lw_memrd1", 4'd4, O_MEMRD);
    step("lw_memrd2", 4'd4, O_MEMRD);
    step("lw_memrd3", 4'd4, O_MEMRD);
    mem_ready = 1'b1;
    step("lw_memwb",  4'd5, O_MEMWB);
    step("lw_done",   4'd1, O_FETCH_R);

    // sw without wait
    opcode = 6'b101011;
    step("sw_decode", 4'd2, O_DECODE);
    step("sw_memadr", 4'd3, O_MEMADR);
    step("sw_memwr",  4'd6, O_MEMWR);
    step("sw_done",   4'd1, O_FETCH_R);

    opcode = 6'b000100;
    step("beq_decode", 4'd2, O_DECODE);
    step("beq_branch", 4'd9, O_BRANCH);
    step("beq_done",   4'd1, O_FETCH_R);

    opcode = 6'b000010;
    step("j_decode", 4'd2, O_DECODE);
    step("j_jump",   4'd10, O_JUMP);
    step("j_done",   4'd1, O_FETCH_R);

    opcode = 6'b111111;
    step("ill_decode", 4'd2, O_DEC_ILL);
    step("ill_done",   4'd1, O_FETCH_R);

    opcode = 6'b001000;
`ifdef MAIN_CTRL_ADDI_EN
    step("addi_decode", 4'd2, O_DECODE);
    step("addi_ex",     4'd11, O_MEMADR);
    step("addi_wb",     4'd12, O_ADDIWB);
    step("addi_done",   4'd1, O_FETCH_R);
`else
    step("addi_decode", 4'd2, O_DEC_ILL);
    step("addi_done",   4'd1, O_FETCH_R);
`endif

    // FETCH wait: ir_write/pc_write follow mem_ready combinationally
    mem_ready = 1'b0;
    #1;
    chk("fetch_wait_outs", {15'd0, outs}, {15'd0, O_FETCH_W});
    step("fetch_held", 4'd1, O_FETCH_W);
    mem_ready = 1'b1;
    #1;
    chk("fetch_ready_outs", {15'd0, outs}, {15'd0, O_FETCH_R});

    // reset while MEMWR is waiting
    opcode = 6'b101011;
    step("rw_decode", 4'd2, O_DECODE);
    step("rw_memadr", 4'd3, O_MEMADR);
    mem_ready = 1'b0;
    step("rw_memwr1", 4'd6, O_MEMWR);
    step("rw_memwr2", 4'd6, O_MEMWR);
    rst_n = 1'b0;
    step("rw_reset", 4'd0, O_ZERO);
    rst_n = 1'b1;
    #1;
    chk("rw_idle", {28'd0, state}, 32'd0);
    step("rw_fetch", 4'd1, O_FETCH_W);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
